// File: rtl/sprite_compositor.sv
// N-sprite pixel compositor: box test, sprite-ROM addressing, colour-key
// transparency, lowest-index priority and per-frame collision flags.
module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          NUM_DIRS    = 4,
    parameter int          ROM_LATENCY = 1,
    parameter logic [23:0] KEY_COLOR   = 24'hFF0000,
    parameter logic [23:0] BG_COLOR    = 24'hFFFFFF,
    parameter int          ADDR_W      = $clog2(NUM_DIRS*SPRITE_W*SPRITE_H),
    parameter int          ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          pix_valid,
    input  logic                          frame_start,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [NUM_SPRITES-1:0]        sprite_en,
    input  logic [10*NUM_SPRITES-1:0]     sprite_x,
    input  logic [10*NUM_SPRITES-1:0]     sprite_y,
    input  logic [3*NUM_SPRITES-1:0]      sprite_dir,
    output logic [ADDR_W*NUM_SPRITES-1:0] rom_addr,
    input  logic [24*NUM_SPRITES-1:0]     rom_data,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          out_valid,
    output logic [ID_W-1:0]               hit_id,
    output logic                          hit,
    output logic [NUM_SPRITES-1:0]        coll_frame
);

    localparam logic [2:0] DIR_MAX = 3'(NUM_DIRS);

    logic [NUM_SPRITES-1:0]        w_inbox;
    logic [ADDR_W*NUM_SPRITES-1:0] w_addr;

    // 11-bit compares so a sprite near X=1023 never wraps onto the left edge
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic [10:0] w_x, w_y, w_dx, w_dy, w_lx, w_ly;
        logic [2:0]  w_dir;
        logic        w_dir_ok, w_in_x, w_in_y;

        assign w_x      = {1'b0, sprite_x[10*g +: 10]};
        assign w_y      = {1'b0, sprite_y[10*g +: 10]};
        assign w_dx     = {1'b0, DrawX};
        assign w_dy     = {1'b0, DrawY};
        assign w_lx     = w_dx - w_x;
        assign w_ly     = w_dy - w_y;
        assign w_dir    = sprite_dir[3*g +: 3];
        assign w_dir_ok = (w_dir != 3'd0) && (w_dir <= DIR_MAX);
        assign w_in_x   = (w_dx >= w_x) && (w_dx < w_x + 11'(SPRITE_W));
        assign w_in_y   = (w_dy >= w_y) && (w_dy < w_y + 11'(SPRITE_H));
        assign w_inbox[g] = sprite_en[g] & w_dir_ok & w_in_x & w_in_y;
        assign w_addr[ADDR_W*g +: ADDR_W] = w_inbox[g] ?
            (ADDR_W'(w_dir - 3'd1) * ADDR_W'(SPRITE_W*SPRITE_H)
             + ADDR_W'(w_ly) * ADDR_W'(SPRITE_W) + ADDR_W'(w_lx)) : '0;
    end

    logic [NUM_SPRITES-1:0] r_a_inbox;
    logic                   r_a_valid;
    logic                   r_a_fs;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            r_a_inbox <= '0;
            r_a_valid <= 1'b0;
            r_a_fs    <= 1'b0;
        end else begin
            rom_addr  <= w_addr;
            r_a_inbox <= w_inbox;
            r_a_valid <= pix_valid;
            r_a_fs    <= frame_start;
        end
    end

    logic [NUM_SPRITES-1:0] r_b_inbox [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] r_b_valid;
    logic [ROM_LATENCY-1:0] r_b_fs;

    // Tag delay matching the external ROM read latency
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < ROM_LATENCY; k++) r_b_inbox[k] <= '0;
            r_b_valid <= '0;
            r_b_fs    <= '0;
        end else begin
            r_b_inbox[0] <= r_a_inbox;
            r_b_valid[0] <= r_a_valid;
            r_b_fs[0]    <= r_a_fs;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                r_b_inbox[k] <= r_b_inbox[k-1];
                r_b_valid[k] <= r_b_valid[k-1];
                r_b_fs[k]    <= r_b_fs[k-1];
            end
        end
    end

    logic [NUM_SPRITES-1:0] w_c_inbox;
    logic                   w_c_valid;
    logic                   w_c_fs;
    logic [NUM_SPRITES-1:0] w_opaque;
    logic                   w_any;
    logic [ID_W-1:0]        w_id;
    logic [23:0]            w_rgb;
    logic                   w_multi;
    logic [NUM_SPRITES-1:0] w_coll;
    logic [NUM_SPRITES-1:0] r_acc;

    assign w_c_inbox = r_b_inbox[ROM_LATENCY-1];
    assign w_c_valid = r_b_valid[ROM_LATENCY-1];
    assign w_c_fs    = r_b_fs[ROM_LATENCY-1];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_opq
        assign w_opaque[g] = w_c_inbox[g] && (rom_data[24*g +: 24] != KEY_COLOR);
    end

    // Descending scan so the lowest opaque index wins
    always_comb begin
        w_any = 1'b0;
        w_id  = '0;
        w_rgb = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_any = 1'b1;
                w_id  = ID_W'(i);
                w_rgb = rom_data[24*i +: 24];
            end
        end
    end

    assign w_multi = |(w_opaque & (w_opaque - NUM_SPRITES'(1)));
    assign w_coll  = (w_c_valid && w_multi) ? w_opaque : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R      <= 8'h00;
            VGA_G      <= 8'h00;
            VGA_B      <= 8'h00;
            out_valid  <= 1'b0;
            hit        <= 1'b0;
            hit_id     <= '0;
            coll_frame <= '0;
            r_acc      <= '0;
        end else begin
            out_valid <= w_c_valid;
            hit       <= w_c_valid & w_any;
            hit_id    <= (w_c_valid && w_any) ? w_id : '0;
            {VGA_R, VGA_G, VGA_B} <= w_c_valid ? w_rgb : 24'h000000;
            if (w_c_fs) begin
                coll_frame <= r_acc | w_coll;
                r_acc      <= '0;
            end else begin
                r_acc <= r_acc | w_coll;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: addressing, transparency, priority,
// bounds, blanking, collision rollover and async reset.
module tb_sprite_compositor;

    logic        Clk;
    logic        Reset_n;
    logic        pix_valid;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  sprite_en;
    logic [39:0] sprite_x, sprite_y;
    logic [11:0] sprite_dir;
    logic [47:0] rom_addr;
    logic [95:0] rom_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid;
    logic [1:0]  hit_id;
    logic        hit;
    logic [3:0]  coll_frame;

    int n_chk = 0;
    int n_err = 0;

    sprite_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid),
        .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
        .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_dir(sprite_dir), .rom_addr(rom_addr), .rom_data(rom_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid),
        .hit_id(hit_id), .hit(hit), .coll_frame(coll_frame)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  en;
        logic [39:0] x, y;
        logic [11:0] dir;
        logic [9:0]  dx, dy;
        logic        pv;
        logic [95:0] rd;
        logic [47:0] addr;
        logic [23:0] rgb;
        logic        ov, h;
        logic [1:0]  id;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] en, input logic [39:0] x, input logic [39:0] y,
                       input logic [11:0] dir, input logic [9:0] dx, input logic [9:0] dy,
                       input logic pv, input logic [95:0] rd, input logic [47:0] addr,
                       input logic [23:0] rgb, input logic ov, input logic h,
                       input logic [1:0] id);
        vec_t v;
        v.en = en; v.x = x; v.y = y; v.dir = dir; v.dx = dx; v.dy = dy;
        v.pv = pv; v.rd = rd; v.addr = addr; v.rgb = rgb; v.ov = ov;
        v.h = h; v.id = id;
        vq.push_back(v);
    endtask

    task automatic idle();
        pix_valid = 1'b0; frame_start = 1'b0; sprite_en = 4'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic overlap(input logic fs);
        pix_valid = 1'b1; frame_start = fs; sprite_en = 4'b0011;
        sprite_x = {20'd0, 10'd200, 10'd200};
        sprite_y = {20'd0, 10'd200, 10'd200};
        sprite_dir = {6'd0, 3'd1, 3'd1};
        DrawX = 10'd210; DrawY = 10'd205;
    endtask

    task automatic clear_px(input logic fs);
        pix_valid = 1'b1; frame_start = fs; sprite_en = 4'b0000;
        DrawX = 10'd5; DrawY = 10'd5;
    endtask

    initial begin
        Reset_n = 1'b0;
        idle();
        DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0;
        sprite_dir = '0; rom_data = '0;

        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd2}, 10'd103, 10'd52, 1'b1,
            {72'd0,24'h123456}, {36'd0,12'd1091}, 24'h123456, 1'b1, 1'b1, 2'd0);
        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd2}, 10'd103, 10'd52, 1'b1,
            {72'd0,24'hFF0000}, {36'd0,12'd1091}, 24'hFFFFFF, 1'b1, 1'b0, 2'd0);
        add(4'b0011, {20'd0,10'd200,10'd200}, {20'd0,10'd200,10'd200}, {6'd0,3'd1,3'd1},
            10'd210, 10'd205, 1'b1, {48'd0,24'h0000FF,24'h00FF00},
            {24'd0,12'd170,12'd170}, 24'h00FF00, 1'b1, 1'b1, 2'd0);
        add(4'b0011, {20'd0,10'd200,10'd200}, {20'd0,10'd200,10'd200}, {6'd0,3'd1,3'd1},
            10'd210, 10'd205, 1'b1, {48'd0,24'h0000FF,24'hFF0000},
            {24'd0,12'd170,12'd170}, 24'h0000FF, 1'b1, 1'b1, 2'd1);
        add(4'b0100, {10'd0,10'd620,20'd0}, 40'd0, {3'd0,3'd1,6'd0}, 10'd639, 10'd3, 1'b1,
            {24'd0,24'hABCDEF,48'd0}, {12'd0,12'd115,24'd0}, 24'hABCDEF, 1'b1, 1'b1, 2'd2);
        add(4'b1000, {10'd1010,30'd0}, 40'd0, {3'd1,9'd0}, 10'd5, 10'd0, 1'b1,
            {24'h010203,72'd0}, 48'd0, 24'hFFFFFF, 1'b1, 1'b0, 2'd0);
        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd0}, 10'd103, 10'd52, 1'b1,
            {72'd0,24'h123456}, 48'd0, 24'hFFFFFF, 1'b1, 1'b0, 2'd0);
        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd5}, 10'd103, 10'd52, 1'b1,
            {72'd0,24'h123456}, 48'd0, 24'hFFFFFF, 1'b1, 1'b0, 2'd0);
        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd2}, 10'd103, 10'd52, 1'b0,
            {72'd0,24'h123456}, {36'd0,12'd1091}, 24'h000000, 1'b0, 1'b0, 2'd0);
        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd4}, 10'd132, 10'd52, 1'b1,
            {72'd0,24'h000001}, 48'd0, 24'hFFFFFF, 1'b1, 1'b0, 2'd0);
        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd4}, 10'd131, 10'd81, 1'b1,
            {72'd0,24'h000001}, {36'd0,12'd4095}, 24'h000001, 1'b1, 1'b1, 2'd0);
        add(4'b0001, {30'd0,10'd100}, {30'd0,10'd50}, {9'd0,3'd4}, 10'd99, 10'd50, 1'b1,
            {72'd0,24'h000001}, 48'd0, 24'hFFFFFF, 1'b1, 1'b0, 2'd0);
        add(4'b1000, 40'd0, 40'd0, {3'd3,9'd0}, 10'd0, 10'd0, 1'b1,
            {24'h445566,72'd0}, {12'd2048,36'd0}, 24'h445566, 1'b1, 1'b1, 2'd3);
        add(4'b0110, {10'd0,10'd20,10'd10,10'd0}, {10'd0,10'd20,10'd10,10'd0},
            {3'd0,3'd1,3'd1,3'd0}, 10'd25, 10'd25, 1'b1,
            {24'd0,24'h222222,24'h111111,24'd0}, {12'd0,12'd165,12'd495,12'd0},
            24'h111111, 1'b1, 1'b1, 2'd1);

        step(2);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'd0);
        chk("rst_coll", 64'(coll_frame), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        Reset_n = 1'b1;
        step(3);

        foreach (vq[i]) begin
            sprite_en = vq[i].en; sprite_x = vq[i].x; sprite_y = vq[i].y;
            sprite_dir = vq[i].dir; DrawX = vq[i].dx; DrawY = vq[i].dy;
            pix_valid = vq[i].pv; frame_start = 1'b0; rom_data = vq[i].rd;
            step(1);
            chk($sformatf("v%0d_addr", i), 64'(rom_addr), 64'(vq[i].addr));
            step(1);
            chk($sformatf("v%0d_early", i), 64'(out_valid), 64'd0);
            step(1);
            chk($sformatf("v%0d_rgb", i), 64'({VGA_R, VGA_G, VGA_B}), 64'(vq[i].rgb));
            chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(vq[i].ov));
            chk($sformatf("v%0d_hit", i), 64'(hit), 64'(vq[i].h));
            chk($sformatf("v%0d_id", i), 64'(hit_id), 64'(vq[i].id));
            idle();
            step(3);
        end

        rom_data = {48'd0, 24'h0000FF, 24'h00FF00};
        clear_px(1'b1); step(1);
        clear_px(1'b0); step(2);
        clear_px(1'b1); step(1);
        clear_px(1'b0); step(2);
        chk("coll_clean", 64'(coll_frame), 64'd0);

        overlap(1'b0); step(1);
        clear_px(1'b0); step(3);
        clear_px(1'b1); step(1);
        clear_px(1'b0); step(2);
        chk("coll_set", 64'(coll_frame), 64'h3);
        clear_px(1'b1); step(1);
        clear_px(1'b0); step(2);
        chk("coll_next", 64'(coll_frame), 64'h0);

        overlap(1'b1); step(1);
        clear_px(1'b1); step(1);
        clear_px(1'b0); step(1);
        chk("coll_tagged", 64'(coll_frame), 64'h3);
        step(1);
        chk("coll_b2b", 64'(coll_frame), 64'h0);
        step(3);

        overlap(1'b1); step(1);
        overlap(1'b0); step(2);
        chk("pre_rst_coll", 64'(coll_frame), 64'h3);
        chk("pre_rst_ov", 64'(out_valid), 64'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'd0);
        chk("mid_rst_hit", 64'(hit), 64'd0);
        chk("mid_rst_coll", 64'(coll_frame), 64'd0);
        chk("mid_rst_addr", 64'(rom_addr), 64'd0);
        step(1);
        Reset_n = 1'b1;
        step(2);
        chk("post_rst_early", 64'(out_valid), 64'd0);
        step(1);
        chk("post_rst_ov", 64'(out_valid), 64'd1);
        chk("post_rst_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'h00FF00);
        idle();
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
